execute_divider: RTL and testbench
==================================

# execute_divider

Iterative 32-bit divider for the execute stage, implementing MIPS DIV/DIVU. It accepts a divide request from execute decode and stalls the front of the pipeline while it iterates. It then presents remainder/quotient as a one-cycle HI/LO write whose three outputs drive the `execute_HILO_enabler`, `execute_HILO_HI` and `execute_HILO_LO` inputs of the execute-to-memory pipeline register.

## Interface
- No parameters; datapath fixed at 32 bits.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  execute holds a DIV/DIVU; held high until the stage advances.
- `signed_div`  in  1  1 = DIV (signed), 0 = DIVU.
- `dividend`  in  32  rs operand; sampled only on the accepting edge.
- `divisor`  in  32  rt operand; sampled only on the accepting edge.
- `annul`  in  1  flush of the execute instruction; aborts the operation in progress.
- `stall_request`  out  1  combinational: (state==IDLE && start && !annul) || state==BUSY.
- `div_HILO_enabler`  out  1  registered; HI/LO write strobe.
- `div_HILO_HI`  out  32  registered; remainder.
- `div_HILO_LO`  out  32  registered; quotient.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE, `start`=1, `annul`=0 → latch operands; clear 6-bit `count`; → BUSY.
  - Divisor zero → skip iteration; → DONE next edge with remainder=dividend, quotient=0xFFFFFFFF.
- BUSY: one restoring step per edge.
  - Shift {rem,quot} left 1.
  - Trial subtract 33-bit rem − divisor; if non-negative, keep the difference and set quot LSB.
  - `count` increments; after step 32 (`count`==31 at the edge) → DONE.
- DONE: `div_HILO_enabler`=1, HI=remainder, LO=quotient; `stall_request`=0; → IDLE next edge.
- `start` is ignored in DONE. The pipeline advances on the DONE edge, so the next instruction's `start` is first seen in IDLE.
- `annul` in BUSY or DONE → IDLE next edge. No `div_HILO_enabler` pulse follows; an enabler already high in DONE is dropped (forced 0) for the cycle `annul` is high.
- `annul` in IDLE blocks acceptance.
- Signed handling (see Configuration):
  - Iterate on absolute values.
  - Quotient negated if operand signs differ.
  - Remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- `div_HILO_HI`/`div_HILO_LO` hold the last result outside DONE; only the enabler qualifies them.

## Timing
- Reset: state IDLE, `count`=0, `div_HILO_enabler`=0, `div_HILO_HI`=0, `div_HILO_LO`=0. `stall_request` is 0 unless `start` is high.
- `rst` wins over every other input. Reset mid-BUSY aborts with no write.
- Start accepted at the edge ending cycle N. BUSY spans cycles N+1..N+32. DONE is cycle N+33 (enabler high). Back in IDLE at N+34.
- Divide-by-zero: DONE at cycle N+2.
- Latency from `start` to HI/LO strobe: 33 cycles (normal), 2 cycles (zero divisor).
- `stall_request` high cycles N..N+32, low in N+33.
- Back-to-back divides: second accepted at the edge ending cycle N+34, at the earliest.
- Operand changes after acceptance have no effect.

## Configuration
- `EXECUTE_DIVIDER_SIGNED_EN` defined:
  - `signed_div` honoured; sign pre/post-processing (abs, negate) compiled in.
  - Adds one negation stage on operand latch and one on DONE result load; cycle counts unchanged.
- Undefined:
  - `signed_div` ignored; every operation is unsigned (DIV behaves as DIVU).
  - No sign logic synthesised.

## Test plan
- Unsigned 100/7, start at cycle 0 → stall cycles 0..32; cycle 33: enabler=1, HI=2, LO=14; idle at 34.
- Signed (macro on) −7/2 (0xFFFFFFF9, 2) → LO=0xFFFFFFFD, HI=0xFFFFFFFF. Macro off, same operands → LO=0x7FFFFFFC, HI=1.
- Divisor 0, dividend 0x12345678 → enabler at cycle 2, HI=0x12345678, LO=0xFFFFFFFF.
- `annul` at cycle 10 of a BUSY divide → IDLE at 11, stall low from 11, no enabler pulse; a new start at 12 completes normally.
- `rst` at cycle 20 mid-BUSY → all outputs 0 on the following cycle, no enabler.
- Two consecutive DIVU (0xFFFFFFFF/0x10000, then 9/3) → first strobe HI=0xFFFF, LO=0xFFFF; second accepted at the edge ending cycle 34, strobe at 67 with HI=0, LO=3.

Source files
------------

// File: rtl/execute_divider_if.sv
// Handshake/result bundle between execute decode and the iterative divider.
interface execute_divider_if;
  logic        start;
  logic        signed_div;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        annul;
  logic        stall_request;
  logic        div_HILO_enabler;
  logic [31:0] div_HILO_HI;
  logic [31:0] div_HILO_LO;

  modport master (
    output start, signed_div, dividend, divisor, annul,
    input  stall_request, div_HILO_enabler, div_HILO_HI, div_HILO_LO
  );

  modport slave (
    input  start, signed_div, dividend, divisor, annul,
    output stall_request, div_HILO_enabler, div_HILO_HI, div_HILO_LO
  );
endinterface

// File: rtl/execute_divider.sv
// Iterative restoring 32-bit divider for MIPS DIV/DIVU.
// One quotient bit per cycle; result presented as a one-cycle HI/LO write.
// Optional macro EXECUTE_DIVIDER_SIGNED_EN compiles in signed (DIV) support;
// without it every operation is unsigned.
module execute_divider (
  input  logic              clk,
  input  logic              rst,
  execute_divider_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_next;
  logic [5:0]  count;
  logic [31:0] rem, quot, dvs, dvd_raw;
  logic        dvz;
  logic        en_r;
  logic [31:0] hi_r, lo_r;

  logic        accept, finish;
  logic [32:0] shifted, diff;
  logic [31:0] rem_step, quot_step;
  logic [31:0] a_abs, b_abs;
  logic [31:0] hi_fin, lo_fin;

`ifdef EXECUTE_DIVIDER_SIGNED_EN
  logic neg_a, neg_b, neg_q, neg_r;
  assign neg_a = bus.signed_div & bus.dividend[31];
  assign neg_b = bus.signed_div & bus.divisor[31];
  assign a_abs = neg_a ? (~bus.dividend + 32'd1) : bus.dividend;
  assign b_abs = neg_b ? (~bus.divisor + 32'd1) : bus.divisor;
`else
  logic sd_unused;
  assign sd_unused = bus.signed_div;
  assign a_abs     = bus.dividend;
  assign b_abs     = bus.divisor;
`endif

  assign accept = (state == IDLE) && bus.start && !bus.annul;
  assign finish = (state == BUSY) && !bus.annul && (dvz || count == 6'd31);

  // One restoring step: shift in next dividend bit, keep difference if it fits
  always_comb begin
    shifted   = {rem, quot[31]};
    diff      = shifted - {1'b0, dvs};
    rem_step  = shifted[31:0];
    quot_step = {quot[30:0], 1'b0};
    if (!diff[32]) begin
      rem_step  = diff[31:0];
      quot_step = {quot[30:0], 1'b1};
    end
  end

  // Final HI/LO value: zero-divisor override, then sign fix-up
  always_comb begin
    hi_fin = rem_step;
    lo_fin = quot_step;
`ifdef EXECUTE_DIVIDER_SIGNED_EN
    if (neg_r) hi_fin = ~rem_step + 32'd1;
    if (neg_q) lo_fin = ~quot_step + 32'd1;
`endif
    if (dvz) begin
      hi_fin = dvd_raw;
      lo_fin = 32'hFFFF_FFFF;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and stall generation
  always_comb begin
    state_next        = state;
    bus.stall_request = 1'b0;
    case (state)
      IDLE: begin
        bus.stall_request = bus.start && !bus.annul;
        if (accept) state_next = BUSY;
      end
      BUSY: begin
        bus.stall_request = 1'b1;
        if (bus.annul)  state_next = IDLE;
        else if (finish) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand latch, iteration and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= 6'd0;
      rem     <= 32'd0;
      quot    <= 32'd0;
      dvs     <= 32'd0;
      dvd_raw <= 32'd0;
      dvz     <= 1'b0;
      en_r    <= 1'b0;
      hi_r    <= 32'd0;
      lo_r    <= 32'd0;
`ifdef EXECUTE_DIVIDER_SIGNED_EN
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
`endif
    end else begin
      en_r <= 1'b0;
      if (accept) begin
        count   <= 6'd0;
        rem     <= 32'd0;
        quot    <= a_abs;
        dvs     <= b_abs;
        dvd_raw <= bus.dividend;
        dvz     <= (bus.divisor == 32'd0);
`ifdef EXECUTE_DIVIDER_SIGNED_EN
        neg_q   <= neg_a ^ neg_b;
        neg_r   <= neg_a;
`endif
      end else if (state == BUSY && !bus.annul) begin
        rem   <= rem_step;
        quot  <= quot_step;
        count <= count + 6'd1;
        if (finish) begin
          en_r <= 1'b1;
          hi_r <= hi_fin;
          lo_r <= lo_fin;
        end
      end
    end
  end

  // A flush in DONE drops the write for that cycle
  assign bus.div_HILO_enabler = en_r && !bus.annul;
  assign bus.div_HILO_HI      = hi_r;
  assign bus.div_HILO_LO      = lo_r;

endmodule

// File: tb/tb_execute_divider.sv
// Directed testbench for execute_divider: vector table plus corner sequences.
module tb_execute_divider;

  logic clk = 1'b0;
  logic rst;
  execute_divider_if bus();

  execute_divider dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_strobe = 0;

  typedef struct {
    string       nm;
    logic        sd;
    logic [31:0] a, b, hi, lo;
    int          lat;
  } vec_t;

  vec_t tbl[8];

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Drive one divide from the current cycle and check stall, latency and result
  task automatic run_div(input string nm, input logic sd, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi,
                         input logic [31:0] elo, input int elat);
    int lat;
    bit seen;
    bus.start      = 1'b1;
    bus.signed_div = sd;
    bus.dividend   = a;
    bus.divisor    = b;
    lat  = 0;
    seen = 0;
    while (!seen && lat <= 40) begin
      #2;
      if (bus.div_HILO_enabler === 1'b1) seen = 1;
      else begin
        chk({nm, " stall"}, 32'(bus.stall_request), 32'd1);
        step();
        lat++;
        bus.dividend = $urandom;
        bus.divisor  = $urandom;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s timeout actual=no strobe expected=strobe at %0d", nm, elat);
    end else begin
      last_strobe = cyc;
      chk({nm, " latency"}, 32'(lat), 32'(elat));
      chk({nm, " HI"}, bus.div_HILO_HI, ehi);
      chk({nm, " LO"}, bus.div_HILO_LO, elo);
      chk({nm, " done stall"}, 32'(bus.stall_request), 32'd0);
      step();
      bus.start = 1'b0;
      #2;
      chk({nm, " idle en"}, 32'(bus.div_HILO_enabler), 32'd0);
      chk({nm, " idle stall"}, 32'(bus.stall_request), 32'd0);
      chk({nm, " hold LO"}, bus.div_HILO_LO, elo);
    end
  endtask

  initial begin
    int c0;
    bit seen;

    tbl[0] = '{"u100_7",   1'b0, 32'd100,       32'd7,         32'd2,         32'd14,        33};
`ifdef EXECUTE_DIVIDER_SIGNED_EN
    tbl[1] = '{"m7_2",     1'b1, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFF,  32'hFFFFFFFD,  33};
    tbl[2] = '{"ovf",      1'b1, 32'h80000000,  32'hFFFFFFFF,  32'd0,         32'h80000000,  33};
    tbl[3] = '{"p7_m2",    1'b1, 32'd7,         32'hFFFFFFFE,  32'd1,         32'hFFFFFFFD,  33};
`else
    tbl[1] = '{"m7_2",     1'b1, 32'hFFFFFFF9,  32'd2,         32'd1,         32'h7FFFFFFC,  33};
    tbl[2] = '{"ovf",      1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'd0,         33};
    tbl[3] = '{"p7_m2",    1'b1, 32'd7,         32'hFFFFFFFE,  32'd7,         32'd0,         33};
`endif
    tbl[4] = '{"dz",       1'b0, 32'h12345678,  32'd0,         32'h12345678,  32'hFFFFFFFF,  2};
    tbl[5] = '{"max_1",    1'b0, 32'hFFFFFFFF,  32'd1,         32'd0,         32'hFFFFFFFF,  33};
    tbl[6] = '{"small",    1'b0, 32'd5,         32'd9,         32'd5,         32'd0,         33};
    tbl[7] = '{"dz_s",     1'b1, 32'd0,         32'd0,         32'd0,         32'hFFFFFFFF,  2};

    rst = 1'b1;
    bus.start = 1'b0; bus.signed_div = 1'b0; bus.annul = 1'b0;
    bus.dividend = 32'd0; bus.divisor = 32'd0;
    step(); step();
    #2;
    chk("reset en", 32'(bus.div_HILO_enabler), 32'd0);
    chk("reset HI", bus.div_HILO_HI, 32'd0);
    chk("reset LO", bus.div_HILO_LO, 32'd0);
    chk("reset stall", 32'(bus.stall_request), 32'd0);
    rst = 1'b0;
    step();

    foreach (tbl[i])
      run_div(tbl[i].nm, tbl[i].sd, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, tbl[i].lat);

    // Back-to-back: second accepted in the first IDLE cycle after DONE
    c0 = cyc;
    run_div("b2b1", 1'b0, 32'hFFFFFFFF, 32'h10000, 32'hFFFF, 32'hFFFF, 33);
    run_div("b2b2", 1'b0, 32'd9, 32'd3, 32'd0, 32'd3, 33);
    chk("b2b strobe cycle", 32'(last_strobe - c0), 32'd67);

    // Annul mid-BUSY, then restart two cycles later
    bus.start = 1'b1; bus.signed_div = 1'b0; bus.dividend = 32'd1000; bus.divisor = 32'd3;
    for (int i = 0; i < 10; i++) begin
      #2;
      if (i == 0 || i == 9) chk("annul busy stall", 32'(bus.stall_request), 32'd1);
      chk("annul busy en", 32'(bus.div_HILO_enabler), 32'd0);
      step();
    end
    bus.annul = 1'b1;
    #2;
    chk("annul cycle stall", 32'(bus.stall_request), 32'd1);
    step();
    bus.annul = 1'b0; bus.start = 1'b0;
    #2;
    chk("after annul stall", 32'(bus.stall_request), 32'd0);
    chk("after annul en", 32'(bus.div_HILO_enabler), 32'd0);
    step();
    run_div("restart", 1'b0, 32'd50, 32'd5, 32'd0, 32'd10, 33);

    // Annul arriving in DONE suppresses the strobe
    bus.start = 1'b1; bus.dividend = 32'd20; bus.divisor = 32'd4;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      #2;
      if (bus.div_HILO_enabler === 1'b1) seen = 1;
      else step();
    end
    chk("done reached", 32'(seen), 32'd1);
    bus.annul = 1'b1;
    #1;
    chk("annul done en", 32'(bus.div_HILO_enabler), 32'd0);
    step();
    bus.annul = 1'b0; bus.start = 1'b0;
    #2;
    chk("post annul done en", 32'(bus.div_HILO_enabler), 32'd0);
    chk("post annul done stall", 32'(bus.stall_request), 32'd0);

    // Annul in IDLE blocks acceptance
    bus.start = 1'b1; bus.annul = 1'b1; bus.dividend = 32'd8; bus.divisor = 32'd2;
    #2;
    chk("idle annul stall", 32'(bus.stall_request), 32'd0);
    step(); step();
    bus.start = 1'b0; bus.annul = 1'b0;
    #2;
    chk("idle annul not busy", 32'(bus.stall_request), 32'd0);
    step();

    // Reset at cycle 20 of a busy divide
    bus.start = 1'b1; bus.dividend = 32'd777; bus.divisor = 32'd5;
    for (int i = 0; i < 20; i++) step();
    rst = 1'b1; bus.start = 1'b0;
    step();
    rst = 1'b0;
    #2;
    chk("rst busy en", 32'(bus.div_HILO_enabler), 32'd0);
    chk("rst busy HI", bus.div_HILO_HI, 32'd0);
    chk("rst busy LO", bus.div_HILO_LO, 32'd0);
    chk("rst busy stall", 32'(bus.stall_request), 32'd0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      #2;
      if (bus.div_HILO_enabler !== 1'b0) seen = 1;
    end
    chk("rst no strobe", 32'(seen), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
